regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised register file with scoreboard and write-through bypass for the decode stage of the pipelined MIPS core. It provides two asynchronous read ports and one synchronous write port. A per-register busy scoreboard lets decode detect read-after-write hazards against in-flight producers. After reset, a sequential clear state machine zeroes the array one entry per cycle.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, when 1 entry 0 reads as zero, is never written and is never busy

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- Ready  out  1  high when clear sequence is done and the block accepts traffic
- Radr1, Radr2  in  ADDR_W  read addresses
- Rdata1, Rdata2  out  DATA_W  read data, combinational
- Busy1, Busy2  out  1  source register has a pending producer, combinational
- Issue  in  1  decode issues an instruction that writes Iadr
- Iadr  in  ADDR_W  destination of issued instruction
- Wen  in  1  writeback valid
- Wadr  in  ADDR_W  writeback address
- Wdata  in  DATA_W  writeback data
- Flush  in  1  pipeline flush; clears entire scoreboard

## Operation
- States: CLEAR, RUN. An edge with RST=1 gives state=CLEAR, cnt=0, all busy bits=0.
- CLEAR: each edge with RST=0 writes 0 to entry cnt and increments cnt. On the edge that writes entry DEPTH-1, the state becomes RUN. Wen, Issue and Flush are ignored in CLEAR.
- RUN: Wen=1 writes Wdata to entry Wadr. Wen=1 clears busy[Wadr]. Issue=1 sets busy[Iadr].
- Issue and Wen to the same address in the same cycle: Issue wins, so busy stays 1. Data is still written.
- Flush=1: all busy bits go to 0 at the edge. Issue in the same cycle is dropped. Wen in the same cycle still writes data.
- ZERO_REG=1: Wen/Issue to address 0 have no effect. Rdata for address 0 is 0 and Busy for address 0 is 0.
- Read path, per port, in priority order:
  - state CLEAR: Rdata=0, Busy=0.
  - Wen=1, Wadr==Radr and the address is writable: Rdata=Wdata (write-through bypass) and Busy=0, because the writeback resolves the hazard in the same cycle.
  - Otherwise: Rdata=array[Radr], Busy=busy[Radr].
- Busy never reflects an Issue from the same cycle; it becomes visible the next cycle.
- Ready = (state==RUN).
- cnt is ADDR_W+1 bits wide and does not wrap in CLEAR.

## Timing
- Reset values: Ready=0, Busy1=Busy2=0, Rdata1=Rdata2=0. In CLEAR, these outputs hold their values regardless of the array contents.
- Clear latency: Ready rises exactly DEPTH rising edges after the last edge with RST=1 (32 for defaults). Holding RST high keeps cnt=0. RST asserted mid-clear or mid-RUN restarts the sequence from entry 0.
- Write latency: data written at edge N is read from the array from cycle N+1. In cycle N it is visible through the bypass.
- Scoreboard latency: Issue at edge N makes Busy=1 from cycle N+1. Wen in cycle M forces Busy=0 combinationally in cycle M, and the bit is cleared from M+1.
- No handshake: the block never back-pressures in RUN. The stall decision belongs to decode (stall = Busy1|Busy2 on used sources).

## Test plan
- Reset/clear: preload garbage via Wen in RUN, assert RST for 1 cycle, then:
  - Ready=0 for 32 cycles and rises on edge 32.
  - Every register reads 0.
  - Wen during CLEAR has no effect.
- Write/read and bypass:
  - Wen, Wadr=5, Wdata=0xDEADBEEF with Radr1=5 in the same cycle gives Rdata1=0xDEADBEEF that cycle.
  - The next cycle with Wen=0 still reads 0xDEADBEEF.
  - Wadr=0, Wdata=0x1234 gives Rdata=0.
- Scoreboard:
  - Issue Iadr=7; the next cycle Radr2=7 gives Busy2=1.
  - Wen Wadr=7 gives Busy2=0 in that cycle and Rdata2=Wdata.
  - The following cycle gives Busy2=0.
- Collision: with busy[9]=1, issue Iadr=9 and Wen Wadr=9, Wdata=0x55 in the same cycle. Next cycle Busy=1 and Rdata=0x55.
- Flush: set busy on 3, 4 and 31, then Flush=1 with Issue Iadr=12. Next cycle all four addresses read Busy=0.
- Reset mid-clear and parameters:
  - Assert RST at clear cycle 10; Ready rises 32 edges after the new RST.
  - Repeat the suite with DATA_W=16, ADDR_W=3, ZERO_REG=0: register 0 becomes writable and busy-capable, and Ready rises after 8 edges.

Source files
------------

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Brief    : Decode-stage register file with a per-entry busy scoreboard,
//             two combinational read ports, one write port, a write-through
//             bypass and a post-reset sequential clear of the array.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              Ready,
    input  logic [ADDR_W-1:0] Radr1,
    input  logic [ADDR_W-1:0] Radr2,
    output logic [DATA_W-1:0] Rdata1,
    output logic [DATA_W-1:0] Rdata2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic              Issue,
    input  logic [ADDR_W-1:0] Iadr,
    input  logic              Wen,
    input  logic [ADDR_W-1:0] Wadr,
    input  logic [DATA_W-1:0] Wdata,
    input  logic              Flush
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // Index of the last entry; the clear walk leaves CLEAR on the edge that writes it.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic              run;
    logic              wr_ok;
    logic              iss_ok;
    logic [DEPTH-1:0]  set_mask;
    logic [DEPTH-1:0]  clr_mask;

    // Qualify traffic: nothing is accepted in CLEAR, and entry 0 is inert when hard-wired.
    always_comb begin
        run      = (state == ST_RUN);
        wr_ok    = run && Wen   && !((ZERO_REG != 0) && (Wadr == '0));
        iss_ok   = run && Issue && !Flush && !((ZERO_REG != 0) && (Iadr == '0));
        set_mask = '0;
        clr_mask = '0;
        if (iss_ok) begin
            set_mask[Iadr] = 1'b1;
        end
        if (wr_ok) begin
            clr_mask[Wadr] = 1'b1;
        end
    end

    // Clear/run sequencer: walk cnt across the array after reset, then run.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else if (state == ST_CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_IDX) begin
                state <= ST_RUN;
            end
        end
    end

    // Storage array: zero-fill during CLEAR, writeback data during RUN.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state == ST_CLEAR) begin
                mem[cnt[ADDR_W-1:0]] <= '0;
            end else if (wr_ok) begin
                mem[Wadr] <= Wdata;
            end
        end
    end

    // Scoreboard: flush wipes everything; otherwise issue sets and wins over writeback clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy <= '0;
        end else if (run) begin
            if (Flush) begin
                busy <= '0;
            end else begin
                busy <= (busy & ~clr_mask) | set_mask;
            end
        end
    end

    // Read port 1: CLEAR gating, then same-cycle writeback bypass, then array/scoreboard.
    always_comb begin
        Rdata1 = '0;
        Busy1  = 1'b0;
        if (!run) begin
            Rdata1 = '0;
            Busy1  = 1'b0;
        end else if (wr_ok && (Wadr == Radr1)) begin
            Rdata1 = Wdata;
            Busy1  = 1'b0;
        end else if ((ZERO_REG != 0) && (Radr1 == '0)) begin
            Rdata1 = '0;
            Busy1  = 1'b0;
        end else begin
            Rdata1 = mem[Radr1];
            Busy1  = busy[Radr1];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        Rdata2 = '0;
        Busy2  = 1'b0;
        if (!run) begin
            Rdata2 = '0;
            Busy2  = 1'b0;
        end else if (wr_ok && (Wadr == Radr2)) begin
            Rdata2 = Wdata;
            Busy2  = 1'b0;
        end else if ((ZERO_REG != 0) && (Radr2 == '0)) begin
            Rdata2 = '0;
            Busy2  = 1'b0;
        end else begin
            Rdata2 = mem[Radr2];
            Busy2  = busy[Radr2];
        end
    end

    // Traffic is accepted once the clear walk has finished.
    always_comb begin
        Ready = run;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Brief    : Directed, table-driven bench for regfile_sb. One instance with
//             default parameters and one with DATA_W=16, ADDR_W=3, ZERO_REG=0
//             share clock, reset and input buses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_sb;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Wen, Issue, Flush;
    logic [4:0]  Wadr, Iadr, Radr1, Radr2;
    logic [31:0] Wdata;

    logic        b_Ready, b_Busy1, b_Busy2;
    logic [31:0] b_Rdata1, b_Rdata2;
    logic        s_Ready, s_Busy1, s_Busy2;
    logic [15:0] s_Rdata1, s_Rdata2;

    int n_tests = 0;
    int n_fail  = 0;
    bit use_small = 1'b0;

    always #5 CLK = ~CLK;

    regfile_sb u_big (
        .CLK(CLK), .RST(RST), .Ready(b_Ready),
        .Radr1(Radr1), .Radr2(Radr2), .Rdata1(b_Rdata1), .Rdata2(b_Rdata2),
        .Busy1(b_Busy1), .Busy2(b_Busy2),
        .Issue(Issue), .Iadr(Iadr), .Wen(Wen), .Wadr(Wadr), .Wdata(Wdata),
        .Flush(Flush)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_small (
        .CLK(CLK), .RST(RST), .Ready(s_Ready),
        .Radr1(Radr1[2:0]), .Radr2(Radr2[2:0]), .Rdata1(s_Rdata1), .Rdata2(s_Rdata2),
        .Busy1(s_Busy1), .Busy2(s_Busy2),
        .Issue(Issue), .Iadr(Iadr[2:0]), .Wen(Wen), .Wadr(Wadr[2:0]), .Wdata(Wdata[15:0]),
        .Flush(Flush)
    );

    typedef struct {
        logic        wen;
        logic [4:0]  wadr;
        logic [31:0] wdata;
        logic        issue;
        logic [4:0]  iadr;
        logic        flush;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
    } vec_t;

    function automatic vec_t mk(int wen, int wadr, logic [31:0] wdata, int issue, int iadr,
                                int flush, int ra1, int ra2, logic [31:0] e1, logic [31:0] e2,
                                int b1, int b2);
        vec_t v;
        v.wen   = wen[0];   v.wadr = wadr[4:0]; v.wdata = wdata;
        v.issue = issue[0]; v.iadr = iadr[4:0]; v.flush = flush[0];
        v.ra1   = ra1[4:0]; v.ra2  = ra2[4:0];
        v.e_rd1 = e1;       v.e_rd2 = e2;
        v.e_b1  = b1[0];    v.e_b2 = b2[0];
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic sel_ready();
        return use_small ? s_Ready : b_Ready;
    endfunction
    function automatic logic [31:0] sel_rd1();
        return use_small ? {16'h0, s_Rdata1} : b_Rdata1;
    endfunction
    function automatic logic [31:0] sel_rd2();
        return use_small ? {16'h0, s_Rdata2} : b_Rdata2;
    endfunction
    function automatic logic [31:0] sel_b1();
        return {31'h0, use_small ? s_Busy1 : b_Busy1};
    endfunction
    function automatic logic [31:0] sel_b2();
        return {31'h0, use_small ? s_Busy2 : b_Busy2};
    endfunction

    task automatic idle();
        Wen = 1'b0; Issue = 1'b0; Flush = 1'b0;
        Wadr = '0; Iadr = '0; Wdata = '0;
    endtask

    task automatic drive(vec_t v);
        Wen = v.wen; Wadr = v.wadr; Wdata = v.wdata;
        Issue = v.issue; Iadr = v.iadr; Flush = v.flush;
        Radr1 = v.ra1; Radr2 = v.ra2;
    endtask

    // Apply one vector for a full cycle; outputs are checked mid-cycle.
    task automatic run_vec(vec_t v, string tag);
        @(negedge CLK);
        drive(v);
        #1;
        chk({tag, " rd1"},   sel_rd1(), v.e_rd1);
        chk({tag, " rd2"},   sel_rd2(), v.e_rd2);
        chk({tag, " busy1"}, sel_b1(), {31'h0, v.e_b1});
        chk({tag, " busy2"}, sel_b2(), {31'h0, v.e_b2});
    endtask

    // Count rising edges after reset release until Ready; 0 reported if it never rises.
    task automatic wait_ready(int expected, string tag);
        int n = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge CLK);
            #1;
            if (sel_ready()) begin
                n = k;
                break;
            end
        end
        idle();
        chk(tag, n, expected);
    endtask

    task automatic pulse_rst();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic read_all(int depth, string tag);
        for (int i = 0; i < depth; i++) begin
            @(negedge CLK);
            idle();
            Radr1 = i[4:0];
            Radr2 = i[4:0];
            #1;
            chk($sformatf("%s rd1[%0d]", tag, i), sel_rd1(), 32'h0);
            chk($sformatf("%s busy2[%0d]", tag, i), sel_b2(), 32'h0);
        end
    endtask

    vec_t tb_big[19];
    vec_t tb_small[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                wen wadr wdata         iss iadr fl ra1 ra2 e_rd1         e_rd2         b1 b2
        tb_big[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  0, 5,  6,  32'hDEADBEEF, 32'h0,        0, 0);
        tb_big[1]  = mk(0, 0,  32'h0,        0, 0,  0, 5,  0,  32'hDEADBEEF, 32'h0,        0, 0);
        tb_big[2]  = mk(1, 0,  32'h00001234, 0, 0,  0, 0,  5,  32'h0,        32'hDEADBEEF, 0, 0);
        tb_big[3]  = mk(0, 0,  32'h0,        0, 0,  0, 0,  0,  32'h0,        32'h0,        0, 0);
        tb_big[4]  = mk(0, 0,  32'h0,        1, 7,  0, 0,  7,  32'h0,        32'h0,        0, 0);
        tb_big[5]  = mk(0, 0,  32'h0,        0, 0,  0, 0,  7,  32'h0,        32'h0,        0, 1);
        tb_big[6]  = mk(1, 7,  32'hCAFEF00D, 0, 0,  0, 7,  7,  32'hCAFEF00D, 32'hCAFEF00D, 0, 0);
        tb_big[7]  = mk(0, 0,  32'h0,        0, 0,  0, 7,  7,  32'hCAFEF00D, 32'hCAFEF00D, 0, 0);
        tb_big[8]  = mk(0, 0,  32'h0,        1, 9,  0, 9,  0,  32'h0,        32'h0,        0, 0);
        tb_big[9]  = mk(1, 9,  32'h00000055, 1, 9,  0, 9,  9,  32'h00000055, 32'h00000055, 0, 0);
        tb_big[10] = mk(0, 0,  32'h0,        0, 0,  0, 9,  9,  32'h00000055, 32'h00000055, 1, 1);
        tb_big[11] = mk(0, 0,  32'h0,        1, 3,  0, 3,  0,  32'h0,        32'h0,        0, 0);
        tb_big[12] = mk(0, 0,  32'h0,        1, 4,  0, 3,  0,  32'h0,        32'h0,        1, 0);
        tb_big[13] = mk(0, 0,  32'h0,        1, 31, 0, 4,  3,  32'h0,        32'h0,        1, 1);
        tb_big[14] = mk(0, 0,  32'h0,        1, 12, 1, 31, 9,  32'h0,        32'h00000055, 1, 1);
        tb_big[15] = mk(0, 0,  32'h0,        0, 0,  0, 3,  4,  32'h0,        32'h0,        0, 0);
        tb_big[16] = mk(0, 0,  32'h0,        0, 0,  0, 31, 12, 32'h0,        32'h0,        0, 0);
        tb_big[17] = mk(1, 20, 32'h20202020, 1, 0,  1, 20, 0,  32'h20202020, 32'h0,        0, 0);
        tb_big[18] = mk(0, 0,  32'h0,        0, 0,  0, 20, 0,  32'h20202020, 32'h0,        0, 0);

        tb_small[0]  = mk(1, 0, 32'h0000BEEF, 0, 0, 0, 0, 1, 32'hBEEF, 32'h0,    0, 0);
        tb_small[1]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'hBEEF, 32'h0,    0, 0);
        tb_small[2]  = mk(0, 0, 32'h0,        1, 0, 0, 0, 0, 32'hBEEF, 32'hBEEF, 0, 0);
        tb_small[3]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 0, 32'hBEEF, 32'hBEEF, 1, 1);
        tb_small[4]  = mk(1, 0, 32'h00001111, 0, 0, 0, 0, 0, 32'h1111, 32'h1111, 0, 0);
        tb_small[5]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h1111, 32'h1111, 0, 0);
        tb_small[6]  = mk(1, 7, 32'h1234ABCD, 0, 0, 0, 7, 7, 32'hABCD, 32'hABCD, 0, 0);
        tb_small[7]  = mk(1, 7, 32'h00005555, 1, 7, 0, 7, 0, 32'h5555, 32'h1111, 0, 0);
        tb_small[8]  = mk(0, 0, 32'h0,        0, 0, 0, 7, 0, 32'h5555, 32'h1111, 1, 0);
        tb_small[9]  = mk(0, 0, 32'h0,        1, 3, 1, 7, 3, 32'h5555, 32'h0,    1, 0);
        tb_small[10] = mk(0, 0, 32'h0,        0, 0, 0, 7, 3, 32'h5555, 32'h0,    0, 0);

        // Initial reset and reset-state outputs.
        idle();
        Radr1 = 5'd5;
        Radr2 = 5'd6;
        RST   = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        chk("reset ready", {31'h0, b_Ready}, 32'h0);
        chk("reset rd1",   b_Rdata1, 32'h0);
        chk("reset rd2",   b_Rdata2, 32'h0);
        chk("reset busy1", {31'h0, b_Busy1}, 32'h0);
        chk("reset busy2", {31'h0, b_Busy2}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        use_small = 1'b0;
        wait_ready(32, "initial clear edges");

        // Preload garbage and some busy bits in RUN.
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            Wen = 1'b1; Wadr = i[4:0]; Wdata = 32'hA5A50000 | i;
        end
        @(negedge CLK);
        idle();
        Issue = 1'b1; Iadr = 5'd10;
        run_vec(mk(0, 0, 32'h0, 0, 0, 0, 5, 10, 32'hA5A50005, 32'hA5A5000A, 0, 1), "preload");

        // Reset with garbage present; traffic during CLEAR must be ignored.
        @(negedge CLK);
        RST = 1'b1; Radr1 = 5'd31; Radr2 = 5'd10;
        @(negedge CLK);
        RST = 1'b0;
        Wen = 1'b1; Wadr = 5'd5; Wdata = 32'hFFFFFFFF;
        Issue = 1'b1; Iadr = 5'd6;
        #1;
        chk("clear gates rd1", b_Rdata1, 32'h0);
        chk("clear gates busy2", {31'h0, b_Busy2}, 32'h0);
        chk("clear ready low", {31'h0, b_Ready}, 32'h0);
        wait_ready(32, "clear edges after garbage");
        read_all(32, "post-clear");

        for (int i = 0; i < 19; i++) begin
            run_vec(tb_big[i], $sformatf("big vec%0d", i));
        end

        // Reset in the middle of the clear walk restarts it.
        pulse_rst();
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        chk("mid-clear ready low", {31'h0, b_Ready}, 32'h0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        wait_ready(32, "restarted clear edges");

        // Small configuration: 8 entries, 16-bit data, entry 0 writable.
        use_small = 1'b1;
        pulse_rst();
        #1;
        chk("small ready low", {31'h0, s_Ready}, 32'h0);
        wait_ready(8, "small clear edges");
        read_all(8, "small post-clear");
        for (int i = 0; i < 11; i++) begin
            run_vec(tb_small[i], $sformatf("small vec%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
